// File: rtl/shiftmul_pkg.sv
// Shared op codes, FSM states and flag bit positions for the multi-cycle shift/multiply unit.
package shiftmul_pkg;

    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_LSL = 3'b001;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shiftmul_count.sv
// Iteration count for one operation, derived from the op code and shift amount.
module shiftmul_count
    import shiftmul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]               op,
    input  logic [7:0]               n,
    output logic [$clog2(WIDTH)+1:0] count
);

    // 9 bits covers WIDTH+1 for the widest legal WIDTH as well as any 8-bit n
    localparam logic [8:0] W9 = 9'(WIDTH);

    logic [8:0] n9;
    logic [8:0] cnt9;

    always_comb begin
        n9   = {1'b0, n};
        cnt9 = '0;
        case (op)
            OP_MUL:         cnt9 = W9;
            OP_LSL, OP_LSR: cnt9 = (n9 > W9) ? (W9 + 9'd1) : n9;
            OP_ASR:         cnt9 = (n9 > W9) ? W9 : n9;
            OP_ROR:         cnt9 = n9 & (W9 - 9'd1);
            default:        cnt9 = '0;
        endcase
        count = ($clog2(WIDTH)+2)'(cnt9);
    end

endmodule

// File: rtl/seq_shiftmul.sv
// Multi-cycle MUL / LSL / LSR / ASR / ROR unit with start/busy/done handshake and {N,Z,C,V} flags.
module seq_shiftmul
    import shiftmul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out
);

    localparam int CW = $clog2(WIDTH) + 2;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_init;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [2:0]       op_q;
    logic             c_in;
    logic             v_in;
    logic             c_sh;
    logic             n_zero;

    logic [WIDTH-1:0] acc_step;
    logic             c_step;
    logic             c_final;
    logic [3:0]       flags_next;
    logic             accept;
    logic             unused_flags;

    // N and Z of the incoming flags are always recomputed from the result
    assign unused_flags = ^{flags_in[FLAG_N], flags_in[FLAG_Z]};

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    shiftmul_count #(.WIDTH(WIDTH)) u_count (
        .op    (op),
        .n     (b[7:0]),
        .count (cnt_init)
    );

    // acc is the product accumulator for MUL and the shift register for shifts
    always_comb begin
        acc_step = acc;
        c_step   = c_sh;
        case (op_q)
            OP_MUL: acc_step = mplier[0] ? (acc + mcand) : acc;
            OP_LSL: begin
                acc_step = {acc[WIDTH-2:0], 1'b0};
                c_step   = acc[WIDTH-1];
            end
            OP_LSR: begin
                acc_step = {1'b0, acc[WIDTH-1:1]};
                c_step   = acc[0];
            end
            OP_ASR: begin
                acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
                c_step   = acc[0];
            end
            OP_ROR: begin
                acc_step = {acc[0], acc[WIDTH-1:1]};
                c_step   = acc[0];
            end
            default: ;
        endcase
    end

    // ROR carry is the result MSB even when the rotation count wraps to zero
    always_comb begin
        c_final = c_in;
        if (is_shift(op_q) && !n_zero)
            c_final = (op_q == OP_ROR) ? acc[WIDTH-1] : c_sh;
        flags_next         = '0;
        flags_next[FLAG_N] = acc[WIDTH-1];
        flags_next[FLAG_Z] = (acc == '0);
        flags_next[FLAG_C] = c_final;
        flags_next[FLAG_V] = v_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            op_q      <= '0;
            c_in      <= 1'b0;
            v_in      <= 1'b0;
            c_sh      <= 1'b0;
            n_zero    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            flags_out <= '0;
        end else if (accept) begin
            state  <= S_RUN;
            cnt    <= cnt_init;
            acc    <= (op == OP_MUL) ? '0 : a;
            mcand  <= a;
            mplier <= b;
            op_q   <= op;
            c_in   <= flags_in[FLAG_C];
            v_in   <= flags_in[FLAG_V];
            c_sh   <= 1'b0;
            n_zero <= (b[7:0] == 8'd0);
            busy   <= 1'b1;
            done   <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (cnt != '0) begin
                        acc    <= acc_step;
                        c_sh   <= c_step;
                        mcand  <= {mcand[WIDTH-2:0], 1'b0};
                        mplier <= {1'b0, mplier[WIDTH-1:1]};
                        cnt    <= cnt - CW'(1);
                    end else begin
                        result    <= acc;
                        flags_out <= flags_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_shiftmul.md
# seq_shiftmul

Multi-cycle shift/multiply unit that sits beside the single-cycle ALU in the ARM datapath. It provides MUL (low word) and the four ARM barrel-shift operations LSL, LSR, ASR and ROR over a parametrised word width. The controller drives it with a start/busy/done handshake. It returns a registered result plus ALU-format flags {N,Z,C,V} for the flag register.

## Interface
- WIDTH, 32, operand/result width; legal values 8, 16, 32, 64, 128.
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle or done.
- op  input  3  operation code from shiftmul_pkg.
- a  input  WIDTH  multiplicand / value to shift.
- b  input  WIDTH  multiplier (MUL); shift amount n = b[7:0] (shifts).
- flags_in  input  4  current {N,Z,C,V}; supplies C and V pass-through.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result/flags_out valid.
- result  output  WIDTH  registered result, held until the next accept.
- flags_out  output  4  registered {N,Z,C,V}.

## Operation
- States: IDLE, RUN, DONE. Reset (reset_n=0, asynchronous) forces IDLE and clears busy, done, result, flags_out and all internal registers to 0.
- **Accept:** start=1 in IDLE or DONE latches a, b, op and flags_in, loads the iteration count N, and enters RUN. start during RUN is ignored; no queueing.
- **Iteration count N:**
  - MUL: WIDTH.
  - LSL/LSR: min(n, WIDTH+1).
  - ASR: min(n, WIDTH).
  - ROR: n mod WIDTH.
  - Illegal op: 0.
- **RUN step:** each edge in RUN with count≠0 performs one step and decrements count.
  - MUL: shift-add. If multiplier LSB=1, add the multiplicand to the accumulator. Shift the multiplicand left 1 and the multiplier right 1. Accumulator is WIDTH bits; overflow is discarded.
  - Shifts: shift by one position. LSL/LSR insert 0, ASR inserts the sign bit, ROR rotates. The bit shifted out is captured as the carry.
- **Completion:** in RUN with count=0, the next edge registers result and flags_out, enters DONE, drops busy and raises done.
- **DONE:** lasts exactly one cycle. Next edge goes to IDLE, or to RUN if start=1.
- **Flags:**
  - N = result[WIDTH-1]; Z = (result==0).
  - V = latched flags_in V for every op.
  - C for shifts with n≠0 = last bit shifted out. Consequences: LSL/LSR with n>WIDTH gives C=0; ASR with n≥WIDTH gives C=a[WIDTH-1]; ROR gives C=result[WIDTH-1], including when n mod WIDTH=0.
  - C = latched flags_in C for MUL, for any shift with n=0, and for illegal op.
- Illegal op: result=a.
- Shift semantics by n:
  - LSL/LSR: n≥WIDTH gives result 0.
  - ASR: n≥WIDTH gives all bits = a[WIDTH-1].
  - n=0: result=a.

## Timing
- busy is high exactly in RUN. done is high exactly in DONE.
- If start is sampled at edge e0, done is high in the cycle after edge e0+N+1. Total latency is N+1 cycles.
  - MUL with WIDTH=32: 33 cycles.
  - Any op with N=0: 1 cycle.
- Back-to-back: start asserted during the done cycle is accepted, so busy rises the cycle after done with no idle gap.
- result and flags_out change only at the completion edge or on reset. They are stable in IDLE.
- Reset asserted mid-RUN aborts the operation immediately: no done pulse, all outputs return to 0.

## Structure
- Package shiftmul_pkg holds:
  - op codes: OP_MUL=3'b000, OP_LSL=3'b001, OP_LSR=3'b010, OP_ASR=3'b011, OP_ROR=3'b100; 3'b101–3'b111 are illegal.
  - state enum {S_IDLE, S_RUN, S_DONE}.
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module shiftmul_count: combinational, computes N from op and n. Width is $clog2(WIDTH)+2 bits to hold WIDTH+1.
- Top level holds the FSM, count register, accumulator/shift register, latched operands and flag logic.

## Test plan
- WIDTH=32, MUL a=7, b=6, flags_in=4'b0011: done 33 cycles after start, result=42, flags_out=4'b0011.
- LSL a=32'h8000_0001, n=1: done after 2 cycles, result=32'h0000_0002, C=1, N=0, Z=0.
- LSR a=32'hFFFF_FFFF, n=40: result=0, Z=1, C=0, done after 34 cycles. Repeat with n=32: result=0, C=1.
- ASR a=32'h8000_0000, n=200: result=32'hFFFF_FFFF, N=1, C=1. ROR a=32'h0000_0001, n=0, flags_in C=1: 1-cycle latency, result=1, C=1.
- MUL started; second start with different operands during RUN ignored; reset_n pulsed low at cycle 10 of a new MUL: outputs 0 with no done; fresh MUL afterwards correct.
- Back-to-back: start held high through done: second op accepted in the done cycle; WIDTH=8 instance MUL 8'hFF*8'h02 gives 8'hFE in 9 cycles.
